var_byte_fifo: RTL

VAR_BYTE_FIFO -- requirements
Module: var_byte_fifo

---
 rtl/var_byte_fifo_pkg.sv | 31 +++
 rtl/var_byte_fifo_lane_rot.sv | 45 ++++
 rtl/var_byte_fifo.sv | 136 +++++++++++++
 3 files changed

// File: rtl/var_byte_fifo_pkg.sv
// Shared types and width helpers for the variable-width byte FIFO.
// Provides byte_t, a ceiling-log2 function and level/count/pointer widths.
package var_byte_fifo_pkg;

    typedef logic [7:0] byte_t;

    localparam int MAX_LANES = 8;

    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

    // width of a byte-count field able to hold 0..lanes
    function automatic int cnt_w(input int lanes);
        return clog2(lanes + 1);
    endfunction

    // width of the level field able to hold 0..depth
    function automatic int lvl_w(input int depth);
        return clog2(depth + 1);
    endfunction

    // width of a pointer indexing 0..depth-1
    function automatic int ptr_w(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/var_byte_fifo_lane_rot.sv
// Byte-lane rotator: per-lane write addresses from the write pointer and
// gathered read bytes from the read pointer (MSB lane = oldest, rest zero).
// Ports: wr_ptr, rd_ptr, rd_bytes, mem (storage view) -> wr_addr, rd_data.
module var_byte_fifo_lane_rot
    import var_byte_fifo_pkg::*;
#(
    parameter int DIN_BYTES   = 4,
    parameter int DOUT_BYTES  = 4,
    parameter int DEPTH_BYTES = 40,
    parameter int PW          = ptr_w(DEPTH_BYTES),
    parameter int RBW         = cnt_w(DOUT_BYTES)
) (
    input  logic [PW-1:0]           wr_ptr,
    input  logic [PW-1:0]           rd_ptr,
    input  logic [RBW-1:0]          rd_bytes,
    input  byte_t                   mem [DEPTH_BYTES],
    output logic [PW-1:0]           wr_addr [DIN_BYTES],
    output logic [8*DOUT_BYTES-1:0] rd_data
);

    // lane offsets never exceed one depth, so one conditional subtract
    // wraps correctly even for a non power-of-two depth
    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p,
                                           input int k);
        int a;
        a = int'(p) + k;
        if (a >= DEPTH_BYTES)
            a = a - DEPTH_BYTES;
        return PW'(a);
    endfunction

    always_comb begin
        for (int i = 0; i < DIN_BYTES; i++)
            wr_addr[i] = wrap(wr_ptr, i);
    end

    always_comb begin
        rd_data = '0;
        for (int j = 0; j < DOUT_BYTES; j++) begin
            if (RBW'(j) < rd_bytes)
                rd_data[8*(DOUT_BYTES-1-j) +: 8] = mem[wrap(rd_ptr, j)];
        end
    end

endmodule

// File: rtl/var_byte_fifo.sv
// Variable-width byte FIFO: appends 1..DIN_BYTES and pops 1..DOUT_BYTES per clock.
// Ports: clk, rst, din/wr_bytes/wr_en/wr_ready, rd_bytes/rd_en/dout/dout_valid,
// level, ovf_err/udf_err. Sticky error flags exist only with VAR_BYTE_FIFO_ERR_EN.
module var_byte_fifo
    import var_byte_fifo_pkg::*;
#(
    parameter int DIN_BYTES   = 4,
    parameter int DOUT_BYTES  = 4,
    parameter int DEPTH_BYTES = 40
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [8*DIN_BYTES-1:0]          din,
    input  logic [cnt_w(DIN_BYTES)-1:0]     wr_bytes,
    input  logic                            wr_en,
    output logic                            wr_ready,
    input  logic [cnt_w(DOUT_BYTES)-1:0]    rd_bytes,
    input  logic                            rd_en,
    output logic [8*DOUT_BYTES-1:0]         dout,
    output logic                            dout_valid,
    output logic [lvl_w(DEPTH_BYTES)-1:0]   level,
    output logic                            ovf_err,
    output logic                            udf_err
);

    localparam int LW  = lvl_w(DEPTH_BYTES);
    localparam int PW  = ptr_w(DEPTH_BYTES);
    localparam int WBW = cnt_w(DIN_BYTES);
    localparam int RBW = cnt_w(DOUT_BYTES);

    byte_t                   mem [DEPTH_BYTES];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           wr_addr [DIN_BYTES];
    logic [8*DOUT_BYTES-1:0] rd_data;
    logic [LW:0]             w_sum;
    logic                    wr_ok;
    logic                    rd_ok;
    logic [LW-1:0]           w_n;
    logic [LW-1:0]           r_n;

    function automatic logic [PW-1:0] adv(input logic [PW-1:0] p,
                                          input int n);
        int a;
        a = int'(p) + n;
        if (a >= DEPTH_BYTES)
            a = a - DEPTH_BYTES;
        return PW'(a);
    endfunction

    // one extra bit so level == DEPTH_BYTES plus a write never truncates
    assign w_sum = {1'b0, level} + (LW+1)'(wr_bytes);

    assign wr_ok = !rst && wr_en && (wr_bytes != '0)
                && (wr_bytes <= WBW'(DIN_BYTES))
                && (w_sum <= (LW+1)'(DEPTH_BYTES));

    assign rd_ok = !rst && rd_en && (rd_bytes != '0)
                && (rd_bytes <= RBW'(DOUT_BYTES))
                && (level >= LW'(rd_bytes));

    assign w_n = wr_ok ? LW'(wr_bytes) : '0;
    assign r_n = rd_ok ? LW'(rd_bytes) : '0;

    assign wr_ready = ((LW+1)'(DEPTH_BYTES) - {1'b0, level})
                   >= (LW+1)'(DIN_BYTES);

    var_byte_fifo_lane_rot #(
        .DIN_BYTES   (DIN_BYTES),
        .DOUT_BYTES  (DOUT_BYTES),
        .DEPTH_BYTES (DEPTH_BYTES),
        .PW          (PW),
        .RBW         (RBW)
    ) u_rot (
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .rd_bytes (rd_bytes),
        .mem      (mem),
        .wr_addr  (wr_addr),
        .rd_data  (rd_data)
    );

    // storage is deliberately left uncleared by reset
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < DIN_BYTES; i++) begin
                if (WBW'(i) < wr_bytes)
                    mem[wr_addr[i]] <= din[8*(DIN_BYTES-1-i) +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= adv(wr_ptr, int'(wr_bytes));
            if (rd_ok) begin
                rd_ptr <= adv(rd_ptr, int'(rd_bytes));
                dout   <= rd_data;
            end
            dout_valid <= rd_ok;
            level      <= level + w_n - r_n;
        end
    end

`ifdef VAR_BYTE_FIFO_ERR_EN
    logic wr_bad;
    logic rd_bad;

    // zero-length requests are no-ops, not errors
    assign wr_bad = wr_en && (wr_bytes != '0) && !wr_ok;
    assign rd_bad = rd_en && (rd_bytes != '0) && !rd_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (wr_bad)
                ovf_err <= 1'b1;
            if (rd_bad)
                udf_err <= 1'b1;
        end
    end
`else
    assign ovf_err = 1'b0;
    assign udf_err = 1'b0;
`endif

endmodule
